bin2bcd_serial: RTL and testbench
=================================

Name: bin2bcd_serial

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the per-digit 4-bit-to-7-segment decoders. Each 4-bit BCD output nibble drives one HEX digit decoder.
- Uses one conversion step per clock, so it scales to wide inputs that a combinational compare-and-subtract cannot handle cheaply.

Parameters:
- WIDTH, 8, bit width of binary input.
- DIGITS, 3, number of BCD output digits. Legal configurations require 10^DIGITS > 2^WIDTH - 1; no overflow detection is provided.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Resetn  input  1  synchronous, active-low reset; sampled on rising edge of Clock.
- Start  input  1  request a conversion; sampled only in IDLE or DONE state.
- Bin  input  WIDTH  unsigned binary value; captured on the edge that accepts Start.
- Busy  output  1  high while a conversion is in progress (SHIFT state).
- Done  output  1  one-cycle pulse: BCD holds a fresh result.
- BCD  output  4*DIGITS  packed result; digit i = BCD[4i+3:4i], digit 0 = ones. Held until the next Done.

Behaviour:
- Reset: Clock and Resetn are the only clock and reset. When Resetn=0 at a rising edge:
  - state<=IDLE; Busy=0, Done=0, BCD=0; internal shift register and counter cleared.
  - Reset overrides all other inputs, including Start on the same edge.
  - Reset mid-conversion aborts the conversion: no Done, BCD=0.
- Internal registers:
  - bin_sr (WIDTH bits).
  - bcd_sr (4*DIGITS bits).
  - cnt (ceil(log2(WIDTH+1)) bits).
  - state (IDLE, SHIFT, DONE).
- IDLE: Busy=0, Done=0.
  - Start=1 at edge t0: bin_sr<=Bin, bcd_sr<=0, cnt<=WIDTH, state<=SHIFT.
- SHIFT: Busy=1, Done=0. At each edge:
  - Every bcd_sr nibble >=5 gets +3 (4-bit add, no carry out of the nibble).
  - Then {bcd_sr,bin_sr} is shifted left by 1; the bcd_sr LSB receives the bin_sr MSB.
  - cnt<=cnt-1.
  - On the edge where cnt==1, after the step: BCD<=final bcd_sr value and state<=DONE.
- DONE: Busy=0, Done=1 for exactly one cycle.
  - Start=1 at this edge is accepted exactly as in IDLE (state<=SHIFT, Bin captured).
  - Otherwise state<=IDLE.
- Latency: Start accepted at edge t0 -> WIDTH shift edges t0+1..t0+WIDTH -> Done=1 in the cycle after edge t0+WIDTH.
  - Sustained throughput with Start held high: one result every WIDTH+1 cycles.
- Start while Busy=1 is ignored, not queued. Changes to Bin after capture do not affect the conversion in progress.
- BCD changes only on the edge entering DONE, or on reset. It is stable in all other cycles.
- Digit nibbles are always 0..9 for legal parameter sets; the downstream decoders never see 10..15.
- Bin=0 converts normally (WIDTH cycles), giving BCD=0 and Done pulsed.

Test Plan:
- Reset, then Bin=8'd0 with Start pulsed -> Busy high for exactly 8 cycles; Done pulses 1 cycle after the 8th shift edge; BCD=12'h000.
- Bin=8'd255, Start pulsed -> BCD=12'h255, Done single-cycle. Then Bin=8'd99 -> 12'h099; Bin=8'd10 -> 12'h010.
- Start held high; Bin=8'd1, then 8'd200 changed while Busy -> first result 12'h001, second conversion starts from DONE with no IDLE cycle:
  - Busy drops for exactly 1 cycle between conversions.
  - The Bin value present at the DONE-state edge is converted.
  - Done period is 9 cycles.
- Start re-pulsed mid-conversion with a different Bin -> ignored; the result matches the originally captured value.
- Resetn=0 on the 4th SHIFT edge of converting 8'd123 -> Busy=0, BCD=0, no Done. After release, converting 8'd123 gives 12'h123.
- WIDTH=4, DIGITS=2: sweep Bin 0..15 -> BCD equals 8'h00..8'h15 (e.g. 4'd12 -> 8'h12), Done after 4 shift edges; high nibble is only ever 0 or 1.

Source files
------------

// File: rtl/bin2bcd_serial.sv
// Serial shift-and-add-3 (double-dabble) binary to packed BCD converter.
// One conversion step per clock; WIDTH steps per conversion, result held until the next Done.
module bin2bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state_reg,  state_next;
    logic [WIDTH-1:0]      bin_sr_reg, bin_sr_next;
    logic [4*DIGITS-1:0]   bcd_sr_reg, bcd_sr_next;
    logic [CNT_W-1:0]      cnt_reg,    cnt_next;
    logic [4*DIGITS-1:0]   bcd_reg,    bcd_next;

    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_shift;
    logic [WIDTH-1:0]      bin_shift;

    // Nibble correction happens before the shift; the +3 wraps inside the nibble.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_sr_reg[4*gi +: 4] >= 4'd5)
                                        ? bcd_sr_reg[4*gi +: 4] + 4'd3
                                        : bcd_sr_reg[4*gi +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_adj[4*DIGITS-2:0], bin_sr_reg[WIDTH-1]};
    assign bin_shift = bin_sr_reg << 1;

    always_comb begin
        state_next  = state_reg;
        bin_sr_next = bin_sr_reg;
        bcd_sr_next = bcd_sr_reg;
        cnt_next    = cnt_reg;
        bcd_next    = bcd_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (Start) begin
                    bin_sr_next = Bin;
                    bcd_sr_next = '0;
                    cnt_next    = CNT_W'(WIDTH);
                    state_next  = SHIFT;
                end else begin
                    state_next  = IDLE;
                end
            end
            SHIFT: begin
                bcd_sr_next = bcd_shift;
                bin_sr_next = bin_shift;
                cnt_next    = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    bcd_next   = bcd_shift;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_reg  <= IDLE;
            bin_sr_reg <= '0;
            bcd_sr_reg <= '0;
            cnt_reg    <= '0;
            bcd_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            bin_sr_reg <= bin_sr_next;
            bcd_sr_reg <= bcd_sr_next;
            cnt_reg    <= cnt_next;
            bcd_reg    <= bcd_next;
        end
    end

    assign Busy = (state_reg == SHIFT);
    assign Done = (state_reg == DONE);
    assign BCD  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Scoreboard bench for bin2bcd_serial: an 8-bit/3-digit and a 4-bit/2-digit instance
// checked cycle by cycle against a timing-rule model and a divide-by-ten reference.
module tb_bin2bcd_serial;

    typedef struct {
        logic [11:0] bcd;
        int          done_edge;
    } item_t;

    logic        clk;
    logic        rn;
    logic        s8, s4;
    logic [7:0]  b8;
    logic [3:0]  b4;
    logic        busy8, done8, busy4, done4;
    logic [11:0] bcd8;
    logic [7:0]  bcd4;

    int          checks = 0;
    int          fails  = 0;
    int          edge_n = 0;
    bit          mon_en = 0;

    item_t       q0[$];
    item_t       q1[$];
    bit          m_active[2];
    int          m_t0[2];
    logic [11:0] m_bcd[2];

    bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) dut8 (
        .Clock(clk), .Resetn(rn), .Start(s8), .Bin(b8),
        .Busy(busy8), .Done(done8), .BCD(bcd8)
    );

    bin2bcd_serial #(.WIDTH(4), .DIGITS(2)) dut4 (
        .Clock(clk), .Resetn(rn), .Start(s4), .Bin(b4),
        .Busy(busy4), .Done(done4), .BCD(bcd4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit q_peek(input int idx, output item_t h);
        h.bcd = '0;
        h.done_edge = 0;
        if (idx == 0) begin
            if (q0.size() == 0) return 1'b0;
            h = q0[0];
        end else begin
            if (q1.size() == 0) return 1'b0;
            h = q1[0];
        end
        return 1'b1;
    endfunction

    task automatic q_pop(input int idx);
        if (idx == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
    endtask

    task automatic cmp(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d edge %0d: got %h required %h", name, idx, edge_n, act, exp);
        end
    endtask

    // Model: a start is accepted when no conversion is running, or from the DONE cycle onwards.
    task automatic model_edge(input int idx, input logic s, input int v, input logic r);
        int    w;
        item_t it;
        w = (idx == 0) ? 8 : 4;
        if (!r) begin
            m_active[idx] = 1'b0;
            m_bcd[idx]    = '0;
            if (idx == 0) q0.delete();
            else          q1.delete();
        end else if (s && (!m_active[idx] || edge_n >= m_t0[idx] + w + 1)) begin
            m_active[idx] = 1'b1;
            m_t0[idx]     = edge_n;
            it.bcd        = ref_bcd(v);
            it.done_edge  = edge_n + w;
            if (idx == 0) q0.push_back(it);
            else          q1.push_back(it);
        end else if (m_active[idx] && edge_n >= m_t0[idx] + w + 1) begin
            m_active[idx] = 1'b0;
        end
    endtask

    task automatic step(input logic st8, input logic [7:0] v8, input logic st4, input logic [3:0] v4, input logic r);
        @(negedge clk);
        s8 = st8; b8 = v8; s4 = st4; b4 = v4; rn = r;
        @(posedge clk);
        edge_n++;
        model_edge(0, st8, int'(v8), r);
        model_edge(1, st4, int'(v4), r);
        mon_en = 1'b1;
    endtask

    task automatic go8(input logic st, input logic [7:0] v);
        step(st, v, 1'b0, 4'($urandom), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, 4'($urandom), 1'b1);
    endtask

    task automatic check_dut(input int idx, input logic busy, input logic done, input logic [11:0] bcd);
        item_t head;
        bit    have, exp_done, exp_busy;
        int    w, nd;
        w  = (idx == 0) ? 8 : 4;
        nd = (idx == 0) ? 3 : 2;
        have = q_peek(idx, head);
        while (have && head.done_edge < edge_n) begin
            checks++;
            fails++;
            $display("FAIL missing_done dut%0d edge %0d: got no Done required result %h at edge %0d",
                     idx, edge_n, head.bcd, head.done_edge);
            q_pop(idx);
            have = q_peek(idx, head);
        end
        exp_done = have && (head.done_edge == edge_n);
        exp_busy = m_active[idx] && (edge_n >= m_t0[idx]) && (edge_n < m_t0[idx] + w);
        cmp("busy", idx, 12'(busy), 12'(exp_busy));
        cmp("done", idx, 12'(done), 12'(exp_done));
        if (exp_done) begin
            m_bcd[idx] = head.bcd;
            q_pop(idx);
            if (done) cmp("result", idx, bcd, head.bcd);
        end
        cmp("bcd_hold", idx, bcd, m_bcd[idx]);
        for (int d = 0; d < nd; d++) begin
            checks++;
            if (bcd[4*d +: 4] > 4'd9) begin
                fails++;
                $display("FAIL digit_range dut%0d edge %0d: digit %0d got %0d required 0..9",
                         idx, edge_n, d, bcd[4*d +: 4]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0, busy8, done8, bcd8);
            check_dut(1, busy4, done4, {4'h0, bcd4});
        end
    end

    initial begin
        int t0;
        s8 = 1'b0; s4 = 1'b0; b8 = '0; b4 = '0; rn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_t0[i] = 0; m_bcd[i] = '0;
        end

        // Reset, including Start asserted during reset
        step(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 8'd55, 1'b1, 4'd9, 1'b0);
        step(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        idle(2);

        // Directed values
        go8(1'b1, 8'd0);   idle(10);
        go8(1'b1, 8'd255); idle(10);
        go8(1'b1, 8'd99);  idle(10);
        go8(1'b1, 8'd10);  idle(10);

        // Start held high, Bin changed while busy
        go8(1'b1, 8'd1);
        for (int i = 0; i < 17; i++) go8(1'b1, 8'd200);
        idle(12);

        // Start re-pulsed mid-conversion is ignored
        go8(1'b1, 8'd77);
        idle(3);
        go8(1'b1, 8'd33);
        idle(10);

        // Reset on the 4th shift edge aborts, then reconvert
        go8(1'b1, 8'd123);
        idle(3);
        step(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        idle(12);
        go8(1'b1, 8'd123);
        idle(10);

        // Narrow instance: full sweep
        for (int v = 0; v < 16; v++) begin
            step(1'b0, 8'd0, 1'b1, 4'(v), 1'b1);
            idle(5);
        end

        // Randomised traffic on both instances with occasional resets
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 4) == 0, 8'($urandom), ($urandom % 3) == 0, 4'($urandom),
                 ($urandom % 113) != 0);
        end
        idle(20);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d results outstanding required 0/0", q0.size(), q1.size());
        end
        t0 = edge_n;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
